// File: rtl/demux_1n_stream.sv
// rtl/demux_1n_stream.sv - registered 1-to-N stream demultiplexer
//
// Routes one DATA_W-bit input beat per cycle into one of N_CH single-entry
// output registers, each with its own valid/ready handshake. The target comes
// from sel (mode=0) or from an internal round-robin pointer (mode=1).
// The round-robin pointer exists only when DEMUX_SCAN_EN is defined. Without
// it, mode is ignored and the target is always sel.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   din          input beat
//   din_valid    input beat present
//   din_ready    beat accepted this cycle (combinational from sel/mode/state)
//   sel, mode    manual target select / 1 = round-robin scan
//   dout         channel k at [k*DATA_W +: DATA_W]
//   dout_valid   channel k holds a beat
//   dout_ready   consumer k takes its beat
//   cur_sel      effective target this cycle
//   err          sticky: a beat was offered to a channel index >= N_CH
module demux_1n_stream #(
  parameter int DATA_W = 8,
  parameter int N_CH = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      din,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   mode,
  output logic [N_CH*DATA_W-1:0] dout,
  output logic [N_CH-1:0]        dout_valid,
  input  logic [N_CH-1:0]        dout_ready,
  output logic [SEL_W-1:0]       cur_sel,
  output logic                   err
);

  localparam logic [SEL_W:0] N_CH_W = (SEL_W+1)'(N_CH);

  logic [SEL_W-1:0]  tgt;
  logic              in_range;
  logic              tgt_full;
  logic              tgt_drain;
  logic              accept;
  logic [N_CH-1:0]   hit;
  logic [N_CH-1:0]   valid_q;
  logic [DATA_W-1:0] data_q [N_CH];
  logic              err_q;

`ifdef DEMUX_SCAN_EN
  logic [SEL_W-1:0] ptr;

  assign tgt = mode ? ptr : sel;

  // The pointer only moves on an accepted beat, so a blocked channel stalls
  // the scan rather than being skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (mode && accept) begin
      if (ptr == SEL_W'(N_CH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + SEL_W'(1);
      end
    end
  end
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign tgt = sel;
`endif

  assign cur_sel  = tgt;
  assign in_range = ({1'b0, tgt} < N_CH_W);

  // Look up the target channel state with a compare loop so an out-of-range
  // target never indexes past the end of the channel vectors.
  always_comb begin
    tgt_full  = 1'b0;
    tgt_drain = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (tgt == SEL_W'(k)) begin
        tgt_full  = valid_q[k];
        tgt_drain = dout_ready[k];
      end
    end
  end

  // Out-of-range beats are swallowed (ready=1) so the source never deadlocks.
  // For in-range targets, a draining channel can be refilled in the same cycle.
  assign din_ready = !in_range || !tgt_full || tgt_drain;
  assign accept    = din_valid && din_ready && in_range;

  always_comb begin
    hit = '0;
    for (int k = 0; k < N_CH; k++) begin
      hit[k] = accept && (tgt == SEL_W'(k));
    end
  end

  // A refill takes priority over a drain, which keeps valid high with new data.
  // The data register is left alone on drain so dout holds its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < N_CH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (hit[k]) begin
          data_q[k]  <= din;
          valid_q[k] <= 1'b1;
        end else if (dout_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (din_valid && !in_range) begin
      err_q <= 1'b1;
    end
  end

  always_comb begin
    dout = '0;
    for (int k = 0; k < N_CH; k++) begin
      dout[k*DATA_W +: DATA_W] = data_q[k];
    end
  end

  assign dout_valid = valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_demux_1n_stream.sv
// tb/tb_demux_1n_stream.sv - randomized self-checking bench for demux_1n_stream
module tb_demux_1n_stream;

`ifdef DEMUX_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        din_valid;
  logic [1:0]  sel;
  logic        mode;
  logic [3:0]  dr;

  logic        rdy4, rdy3;
  logic [31:0] dout4;
  logic [23:0] dout3;
  logic [3:0]  dv4;
  logic [2:0]  dv3;
  logic [1:0]  cs4, cs3;
  logic        err4, err3;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference state per instance: 0 = four channels, 1 = three channels
  logic [7:0] md [2][4];
  bit         mv [2][4];
  int         mp [2];
  bit         me [2];

  always #5 clk = ~clk;

  demux_1n_stream #(.DATA_W(8), .N_CH(4)) u4 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy4),
    .sel(sel), .mode(mode), .dout(dout4), .dout_valid(dv4), .dout_ready(dr),
    .cur_sel(cs4), .err(err4)
  );

  demux_1n_stream #(.DATA_W(8), .N_CH(3)) u3 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy3),
    .sel(sel), .mode(mode), .dout(dout3), .dout_valid(dv3), .dout_ready(dr[2:0]),
    .cur_sel(cs3), .err(err3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int n_of(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic int tgt_of(input int i);
    return (SCAN && mode) ? mp[i] : int'(sel);
  endfunction

  function automatic bit ready_of(input int i);
    int t = tgt_of(i);
    if (t >= n_of(i)) return 1'b1;
    return !mv[i][t] || dr[t];
  endfunction

  task automatic compare_all();
    logic [63:0] ed, ev;
    for (int i = 0; i < 2; i++) begin
      ed = '0;
      ev = '0;
      for (int k = 0; k < n_of(i); k++) begin
        ed[k*8 +: 8] = md[i][k];
        ev[k]        = mv[i][k];
      end
      if (i == 0) begin
        check("n4_dout", 64'(dout4), ed);
        check("n4_valid", 64'(dv4), ev);
        check("n4_ready", 64'(rdy4), 64'(ready_of(0)));
        check("n4_cur_sel", 64'(cs4), 64'(tgt_of(0) % 4));
        check("n4_err", 64'(err4), 64'(me[0]));
      end else begin
        check("n3_dout", 64'(dout3), ed);
        check("n3_valid", 64'(dv3), ev);
        check("n3_ready", 64'(rdy3), 64'(ready_of(1)));
        check("n3_cur_sel", 64'(cs3), 64'(tgt_of(1) % 4));
        check("n3_err", 64'(err3), 64'(me[1]));
      end
    end
  endtask

  // Applies the block's rules to the reference for the inputs present at this edge.
  task automatic model_edge();
    int t, n;
    bit acc;
    for (int i = 0; i < 2; i++) begin
      n = n_of(i);
      if (rst) begin
        for (int k = 0; k < 4; k++) begin
          md[i][k] = '0;
          mv[i][k] = 1'b0;
        end
        mp[i] = 0;
        me[i] = 1'b0;
      end else begin
        t   = tgt_of(i);
        acc = din_valid && ready_of(i) && (t < n);
        for (int k = 0; k < n; k++) begin
          if (mv[i][k] && dr[k]) mv[i][k] = 1'b0;
        end
        if (acc) begin
          md[i][t] = din;
          mv[i][t] = 1'b1;
          if (SCAN && mode) mp[i] = (mp[i] + 1) % n;
        end
        if (din_valid && t >= n) me[i] = 1'b1;
      end
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    #1;
    if (chk_en) compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; sel = '0; mode = 1'b0; dr = 4'hF;
    @(negedge clk);
    cycle();
    chk_en = 1'b1;
    cycle();

    // Single route to channel 2
    rst = 1'b0; sel = 2'd2; din = 8'hA5; din_valid = 1'b1;
    cycle();
    din_valid = 1'b0;
    #1;
    check("route_valid", 64'(dv4), 64'h4);
    check("route_data", 64'(dout4[23:16]), 64'hA5);
    check("route_err", 64'(err4), 64'h0);
    cycle();

    // Backpressure on channel 1
    sel = 2'd1; dr = 4'b1101; din = 8'h11; din_valid = 1'b1;
    cycle();
    din = 8'h22;
    #1;
    check("bp_blocked", 64'(rdy4), 64'h0);
    cycle();
    dr = 4'hF;
    #1;
    check("bp_release", 64'(rdy4), 64'h1);
    cycle();
    din_valid = 1'b0;
    #1;
    check("bp_data", 64'(dout4[15:8]), 64'h22);
    check("bp_valid", 64'(dv4[1]), 64'h1);
    cycle();

    // Round-robin over six beats
    if (SCAN) begin
      mode = 1'b1;
      for (int b = 0; b < 6; b++) begin
        din = 8'(b); din_valid = 1'b1;
        #1;
        check("rr_cur_sel", 64'(cs4), 64'(b % 4));
        cycle();
        din_valid = 1'b0;
        #1;
        check("rr_data", 64'(dout4[(b % 4)*8 +: 8]), 64'(b));
      end
      mode = 1'b0;
      cycle();
    end

    // Out-of-range select on the three-channel instance
    sel = 2'd3; din = 8'h3C; din_valid = 1'b1;
    #1;
    check("oor_ready", 64'(rdy3), 64'h1);
    cycle();
    din_valid = 1'b0;
    #1;
    check("oor_err", 64'(err3), 64'h1);
    check("oor_valid", 64'(dv3), 64'h0);
    cycle();
    cycle();

    // Mid-stream reset with channels 0 and 3 stuck full
    dr = 4'h0; sel = 2'd0; din = 8'hC0; din_valid = 1'b1;
    cycle();
    sel = 2'd3; din = 8'hC3;
    cycle();
    din_valid = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("rst_valid", 64'(dv4), 64'h0);
    check("rst_dout", 64'(dout4), 64'h0);
    check("rst_err", 64'(err3), 64'h0);
    check("rst_ready", 64'(rdy4), 64'h1);
    cycle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      din       = 8'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      sel       = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      dr        = 4'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
